// File: rtl/ram_wb_slave_port.sv
// Wishbone B3 slave front-end for port A of the dual-port single-clock RAM.
// Classic and incrementing-burst cycles become RAM word accesses. Partial
// writes are merged by read-modify-write because the RAM has no byte enables.
module ram_wb_slave_port #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int MEM_SIZE     = 2048,
  parameter int WB_ADR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WB_ADR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic [2:0]              wb_cti_i,
  input  logic [1:0]              wb_bte_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [ADDR_WIDTH-1:0]   ram_adr_o,
  output logic [DATA_WIDTH-1:0]   ram_d_o,
  output logic                    ram_we_o,
  input  logic [DATA_WIDTH-1:0]   ram_q_i
);

  typedef enum logic [2:0] {IDLE, RD, WR_ACK, RMW, ERR} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [ADDR_WIDTH-1:0] incAddr;
  logic [ADDR_WIDTH-1:0] wrapMask;
  logic [ADDR_WIDTH-1:0] nextAddr;
  logic                  busReq;
  logic                  inRange;
  logic                  fullSel;
  logic                  burstGo;
  logic                  unused_adr;

  assign wordIdx    = wb_adr_i[ADDR_WIDTH+1:2];
  assign unused_adr = ^wb_adr_i[1:0];
  assign inRange    = (wb_adr_i[WB_ADR_WIDTH-1:ADDR_WIDTH+2] == '0) &&
                      ({{(32-ADDR_WIDTH){1'b0}}, wordIdx} < 32'(MEM_SIZE));
  // Reset gates the bus request so nothing is acked or written while rst_n is low.
  assign busReq     = wb_cyc_i & wb_stb_i & rst_n;
  assign fullSel    = &wb_sel_i;
  assign burstGo    = (state_q == RD) & busReq & (wb_cti_i == 3'b010);
  assign wb_dat_o   = wb_ack_o ? ram_q_i : '0;

  // Next burst word: linear increment, or increment confined to an aligned wrap block.
  always_comb begin
    wrapMask = '0;
    case (wb_bte_i)
      2'b01:   wrapMask = ADDR_WIDTH'(3);
      2'b10:   wrapMask = ADDR_WIDTH'(7);
      2'b11:   wrapMask = ADDR_WIDTH'(15);
      default: wrapMask = '0;
    endcase
    incAddr = addr_q + 1'b1;
    if (wb_bte_i == 2'b00) nextAddr = incAddr;
    else                   nextAddr = (addr_q & ~wrapMask) | (incAddr & wrapMask);
  end

  // State and word-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic; dropping cyc always returns to IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (busReq) begin
          addr_d = wordIdx;
          if (!inRange)      state_d = ERR;
          else if (!wb_we_i) state_d = RD;
          else if (fullSel)  state_d = WR_ACK;
          else               state_d = RMW;
        end
      end
      RD: begin
        if (busReq) begin
          if (wb_cti_i == 3'b010) addr_d  = nextAddr;
          else                    state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!wb_cyc_i) state_d = IDLE;
  end

  // Bus terminations and RAM port A drive for the current state.
  always_comb begin
    wb_ack_o  = 1'b0;
    wb_err_o  = 1'b0;
    ram_we_o  = 1'b0;
    ram_adr_o = wordIdx;
    ram_d_o   = wb_dat_i;
    case (state_q)
      IDLE: begin
        ram_we_o = busReq & inRange & wb_we_i & fullSel;
      end
      RD: begin
        wb_ack_o  = busReq;
        ram_adr_o = burstGo ? nextAddr : addr_q;
      end
      WR_ACK: begin
        wb_ack_o  = busReq;
        ram_adr_o = addr_q;
      end
      RMW: begin
        ram_adr_o = addr_q;
        for (int i = 0; i < DATA_WIDTH/8; i++)
          ram_d_o[8*i +: 8] = wb_sel_i[i] ? wb_dat_i[8*i +: 8] : ram_q_i[8*i +: 8];
        ram_we_o  = busReq;
        wb_ack_o  = busReq;
      end
      ERR: begin
        wb_err_o  = busReq;
        ram_adr_o = addr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_wb_slave_port.sv
// Self-checking bench for ram_wb_slave_port with a behavioural synchronous RAM
// on port A. One vector is one bus cycle: inputs are driven after the falling
// edge and outputs are sampled 1 ns later, well away from the rising edge.
module tb_ram_wb_slave_port;

  typedef struct {
    logic        cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        expAck, expErr, expWe;
    logic        chkDat;
    logic [31:0] expDat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [10:0] ram_adr_o;
  logic [31:0] ram_d_o, ram_q_i;
  logic        ram_we_o;

  logic [31:0] mem [0:2047];
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  ram_wb_slave_port dut (
    .clk(clk), .rst_n(rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .ram_adr_o(ram_adr_o), .ram_d_o(ram_d_o), .ram_we_o(ram_we_o),
    .ram_q_i(ram_q_i)
  );

  // Behavioural RAM: preloaded pattern, read-first, q valid one cycle after address.
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] <= 32'hC0DE0000 | i;
    mem[8] <= 32'h11223344;
    forever begin
      @(posedge clk);
      ram_q_i <= mem[ram_adr_o];
      if (ram_we_o) mem[ram_adr_o] <= ram_d_o;
    end
  end

  function automatic vec_t V(input logic cyc, stb, we, input logic [31:0] adr, dat,
                             input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte,
                             input logic ack, err, wev, chk, input logic [31:0] expDat);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
    v.cti = cti; v.bte = bte; v.expAck = ack; v.expErr = err; v.expWe = wev;
    v.chkDat = chk; v.expDat = expDat;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    wb_cyc_i = v.cyc; wb_stb_i = v.stb; wb_we_i = v.we; wb_adr_i = v.adr;
    wb_dat_i = v.dat; wb_sel_i = v.sel; wb_cti_i = v.cti; wb_bte_i = v.bte;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic runVec(input vec_t v, input string tag);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput({tag, " ack"}, 32'(wb_ack_o), 32'(v.expAck));
    checkOutput({tag, " err"}, 32'(wb_err_o), 32'(v.expErr));
    checkOutput({tag, " we"},  32'(ram_we_o), 32'(v.expWe));
    if (v.chkDat) checkOutput({tag, " dat"}, wb_dat_o, v.expDat);
  endtask

  initial begin
    vec_t idle;
    idle = V(0, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 0, 0, 0, 1, 0);

    // Classic full write / readback, partial write / readback, wrap4 burst,
    // out-of-range read and write, linear burst wrapping past the last word.
    vecs.push_back(V(1,1,1,32'h10,32'hDEADBEEF,4'hF,3'b000,2'b00, 0,0,1, 1,0));
    vecs.push_back(V(1,1,1,32'h10,32'hDEADBEEF,4'hF,3'b000,2'b00, 1,0,0, 0,0));
    vecs.push_back(idle);
    vecs.push_back(V(1,1,0,32'h10,0,4'hF,3'b000,2'b00, 0,0,0, 1,0));
    vecs.push_back(V(1,1,0,32'h10,0,4'hF,3'b000,2'b00, 1,0,0, 1,32'hDEADBEEF));
    vecs.push_back(idle);
    vecs.push_back(V(1,1,1,32'h20,32'hAABBCCDD,4'b0101,3'b000,2'b00, 0,0,0, 1,0));
    vecs.push_back(V(1,1,1,32'h20,32'hAABBCCDD,4'b0101,3'b000,2'b00, 1,0,1, 0,0));
    vecs.push_back(idle);
    vecs.push_back(V(1,1,0,32'h20,0,4'hF,3'b000,2'b00, 0,0,0, 1,0));
    vecs.push_back(V(1,1,0,32'h20,0,4'hF,3'b000,2'b00, 1,0,0, 1,32'h11BB33DD));
    vecs.push_back(idle);
    vecs.push_back(V(1,1,0,32'h18,0,4'hF,3'b010,2'b01, 0,0,0, 1,0));
    vecs.push_back(V(1,1,0,32'h18,0,4'hF,3'b010,2'b01, 1,0,0, 1,32'hC0DE0006));
    vecs.push_back(V(1,1,0,32'h18,0,4'hF,3'b010,2'b01, 1,0,0, 1,32'hC0DE0007));
    vecs.push_back(V(1,1,0,32'h18,0,4'hF,3'b010,2'b01, 1,0,0, 1,32'hDEADBEEF));
    vecs.push_back(V(1,1,0,32'h18,0,4'hF,3'b111,2'b01, 1,0,0, 1,32'hC0DE0005));
    vecs.push_back(idle);
    vecs.push_back(V(1,1,0,32'h2000,0,4'hF,3'b000,2'b00, 0,0,0, 1,0));
    vecs.push_back(V(1,1,0,32'h2000,0,4'hF,3'b000,2'b00, 0,1,0, 1,0));
    vecs.push_back(idle);
    vecs.push_back(V(1,1,1,32'h2000,32'h12345678,4'hF,3'b000,2'b00, 0,0,0, 1,0));
    vecs.push_back(V(1,1,1,32'h2000,32'h12345678,4'hF,3'b000,2'b00, 0,1,0, 1,0));
    vecs.push_back(idle);
    vecs.push_back(V(1,1,0,32'h1FFC,0,4'hF,3'b010,2'b00, 0,0,0, 1,0));
    vecs.push_back(V(1,1,0,32'h1FFC,0,4'hF,3'b010,2'b00, 1,0,0, 1,32'hC0DE07FF));
    vecs.push_back(V(1,1,0,32'h1FFC,0,4'hF,3'b111,2'b00, 1,0,0, 1,32'hC0DE0000));
    vecs.push_back(idle);

    // Reset state
    rst_n = 1'b0;
    applyStimulus(idle);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset ack", 32'(wb_ack_o), 32'h0);
    checkOutput("reset err", 32'(wb_err_o), 32'h0);
    checkOutput("reset we",  32'(ram_we_o), 32'h0);
    checkOutput("reset dat", wb_dat_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) runVec(vecs[i], $sformatf("vec%0d", i));

    // Wrap4 burst with a two-cycle master wait after beat 2, then a new read proving IDLE
    runVec(V(1,1,0,32'h18,0,4'hF,3'b010,2'b01, 0,0,0, 1,0), "gap accept");
    runVec(V(1,1,0,32'h18,0,4'hF,3'b010,2'b01, 1,0,0, 1,32'hC0DE0006), "gap beat1");
    runVec(V(1,1,0,32'h18,0,4'hF,3'b010,2'b01, 1,0,0, 1,32'hC0DE0007), "gap beat2");
    runVec(V(1,0,0,32'h18,0,4'hF,3'b010,2'b01, 0,0,0, 1,0), "gap wait1");
    runVec(V(1,0,0,32'h18,0,4'hF,3'b010,2'b01, 0,0,0, 1,0), "gap wait2");
    runVec(V(1,1,0,32'h18,0,4'hF,3'b010,2'b01, 1,0,0, 1,32'hDEADBEEF), "gap beat3");
    runVec(V(1,1,0,32'h18,0,4'hF,3'b111,2'b01, 1,0,0, 1,32'hC0DE0005), "gap beat4");
    runVec(V(1,1,0,32'h20,0,4'hF,3'b000,2'b00, 0,0,0, 1,0), "gap idle");
    runVec(V(1,1,0,32'h20,0,4'hF,3'b000,2'b00, 1,0,0, 1,32'h11BB33DD), "gap read");
    runVec(idle, "gap end");

    // Reset asserted during the RMW cycle aborts the partial write
    runVec(V(1,1,1,32'h24,32'h0,4'b0011,3'b000,2'b00, 0,0,0, 1,0), "rmw accept");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rmw reset ack", 32'(wb_ack_o), 32'h0);
    checkOutput("rmw reset we",  32'(ram_we_o), 32'h0);
    @(negedge clk);
    applyStimulus(idle);
    rst_n = 1'b1;
    runVec(V(1,1,0,32'h24,0,4'hF,3'b000,2'b00, 0,0,0, 1,0), "rmw read idle");
    runVec(V(1,1,0,32'h24,0,4'hF,3'b000,2'b00, 1,0,0, 1,32'hC0DE0009), "rmw readback");
    runVec(idle, "rmw end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
